// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   size_e    : access size encoding (byte, half, word, double)
//   state_e   : access FSM states
//   LANES     : byte lanes of the default 32-bit datapath
//   lanes_of  : byte lanes for a given data width
//   eff_size  : folds a doubleword request to word on a 32-bit datapath
//   size_mask : low address bits that must be zero for a naturally aligned access
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int XLEN_DEFAULT = 32;
  localparam int LANES        = XLEN_DEFAULT / 8;

  function automatic int lanes_of(input int xlen);
    return xlen / 8;
  endfunction

  function automatic size_e eff_size(input logic [1:0] sz, input int xlen);
    size_e r;
    case (sz)
      2'b00:   r = SZ_B;
      2'b01:   r = SZ_H;
      2'b10:   r = SZ_W;
      2'b11:   r = (xlen == 64) ? SZ_D : SZ_W;
      default: r = SZ_W;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] size_mask(input size_e sz);
    logic [2:0] m;
    case (sz)
      SZ_B:    m = 3'd0;
      SZ_H:    m = 3'd1;
      SZ_W:    m = 3'd3;
      SZ_D:    m = 3'd7;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Request/acknowledge data-memory port of the load/store unit.
//   master (LSU)   : drives mem_req, mem_we, mem_addr, mem_be, mem_wdata
//   slave (memory) : drives mem_ack, mem_rdata
// Lane order is big-endian: byte offset 0 is the MSB lane and the MSB of mem_be.
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction: picks the lanes at the byte offset of a
// big-endian memory word and sign- or zero-extends them to XLEN.
//   off_i      : byte offset inside the memory word (already size-aligned)
//   size_i     : access size
//   unsigned_i : 1 zero-extend, 0 sign-extend
//   rdata_i    : raw memory word
//   data_o     : extended load data
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0] off_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] sh_s;
  logic [6:0]      drop_s;

  // Move the addressed lane to the top, then shift it back down with the
  // requested extension; the right shift does the sign/zero fill for free.
  always_comb begin
    sh_s = rdata_i << {off_i, 3'b000};
    case (size_i)
      SZ_B:    drop_s = 7'(XLEN - 8);
      SZ_H:    drop_s = 7'(XLEN - 16);
      SZ_W:    drop_s = 7'(XLEN - 32);
      default: drop_s = 7'd0;
    endcase
    if (unsigned_i) begin
      data_o = sh_s >> drop_s;
    end else begin
      data_o = $signed(sh_s) >>> drop_s;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage access unit: byte/half/word (and double at XLEN=64) loads and
// stores over a request/acknowledge memory port with arbitrary wait states.
// Stalls the pipeline while an access is in flight and returns extended load
// data tagged with its destination register.
//   clk, reset          : clock, asynchronous active-high reset
//   req_*               : pipeline request, held stable while stall is high
//   stall               : pipeline must hold (combinational)
//   resp_valid/rdata/rd : one-cycle load completion
//   misalign            : one-cycle misaligned-access pulse
//   mem                 : memory port (load_store_unit_if.master)
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// accesses skip memory and pulse misalign; otherwise the offending low address
// bits are cleared and the access proceeds.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              misalign,
  load_store_unit_if.master mem
);

  localparam int NLANES = lanes_of(XLEN);
  localparam int OFF_W  = $clog2(NLANES);
  localparam logic [NLANES-1:0] BE_ALL = '1;
  // Byte-enable patterns for offset 0; shifted right by the byte offset.
  localparam logic [NLANES-1:0] BE_B = BE_ALL << (NLANES - 1);
  localparam logic [NLANES-1:0] BE_H = BE_ALL << (NLANES - 2);
  localparam logic [NLANES-1:0] BE_W = BE_ALL << (NLANES - 4);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NLANES-1:0] mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              misalign_q, misalign_d;
  logic              write_q, write_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [4:0]        rd_q, rd_d;

  size_e             sz_s;
  logic [2:0]        mask3_s;
  logic [OFF_W-1:0]  mask_s;
  logic [OFF_W-1:0]  off_raw_s;
  logic [OFF_W-1:0]  off_s;
  logic              misalign_hit_s;
  logic [NLANES-1:0] be_s;
  logic [XLEN-1:0]   wdata_s;
  logic [XLEN-1:0]   ld_data_s;

  assign sz_s      = eff_size(req_size, XLEN);
  assign mask3_s   = size_mask(sz_s);
  assign mask_s    = OFF_W'(mask3_s);
  assign off_raw_s = req_addr[OFF_W-1:0];
  // Silent alignment: bits below the access size are ignored.
  assign off_s     = off_raw_s & ~mask_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_hit_s = |(off_raw_s & mask_s);
`else
  assign misalign_hit_s = 1'b0;
`endif

  // Store lane encoding: replicate the data across lanes, enable only the
  // lanes at the access offset.
  always_comb begin
    be_s    = BE_ALL;
    wdata_s = req_wdata;
    case (sz_s)
      SZ_B: begin
        be_s    = BE_B >> off_s;
        wdata_s = {NLANES{req_wdata[7:0]}};
      end
      SZ_H: begin
        be_s    = BE_H >> off_s;
        wdata_s = {(NLANES / 2){req_wdata[15:0]}};
      end
      SZ_W: begin
        be_s    = BE_W >> off_s;
        wdata_s = {(NLANES / 4){req_wdata[31:0]}};
      end
      default: begin
        be_s    = BE_ALL;
        wdata_s = req_wdata;
      end
    endcase
  end

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_i    (mem.mem_rdata),
    .data_o     (ld_data_s)
  );

  // FSM next state and registered outputs.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    misalign_d   = misalign_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    rd_d         = rd_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = sz_s;
          uns_d   = req_unsigned;
          off_d   = off_s;
          rd_d    = req_rd;
          if (misalign_hit_s) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_d    = be_s;
            mem_wdata_d = wdata_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!write_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data_s;
            resp_rd_d    = rd_q;
          end else begin
            resp_valid_d = 1'b0;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= 5'd0;
      misalign_q   <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      off_q        <= '0;
      rd_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      misalign_q   <= misalign_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  assign stall         = req_valid && (state_q != DONE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_rd       = resp_rd_q;
  assign misalign      = misalign_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
